// File: rtl/poci_pkg.sv
// Shared types and defaults for the peripheral-out (read-back) side of the SPI register interface.
package poci_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } poci_state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;
   localparam logic [ADDR_W_DEF-1:0] NULL_ADDR = '0;

endpackage

// File: rtl/poci_if.sv
// Bundle between the inbound deserialiser, the register read mux and the serializer.
interface poci_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);

   logic [ADDR_W-1:0] addr_in;
   logic              addr_load;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              serial_out;
   logic              tx_active;
   logic              byte_loaded;

   modport master (
      output addr_in, addr_load, rd_data,
      input  rd_addr, serial_out, tx_active, byte_loaded
   );

   modport slave (
      input  addr_in, addr_load, rd_data,
      output rd_addr, serial_out, tx_active, byte_loaded
   );

endinterface

// File: rtl/poci_shift_register.sv
// Parallel-load, MSB-first left shifter; clear beats load, load beats shift.
module poci_shift_register #(
   parameter int DATA_W = 8
) (
   input  logic              sclk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              dout
);

   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;

   always_comb begin
      shift_d = shift_q;
      if (clr) begin
         shift_d = '0;
      end else if (load) begin
         shift_d = din;
      end else if (shift) begin
         shift_d = {shift_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign dout = shift_q[DATA_W-1];

endmodule

// File: rtl/poci_serializer.sv
// Streams registers MSB-first starting at a captured address, auto-incrementing (wrapping past 0) until rstn ends the session.
module poci_serializer
   import poci_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LAST_ADDR = 255
) (
   input  logic   sclk,
   input  logic   rstn,
   poci_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_LOAD  = LOAD;
   localparam logic [1:0] ST_SHIFT = SHIFT;

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_A) ? ADDR_W'(1) : a + ADDR_W'(1);
   endfunction

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              byte_loaded_q, byte_loaded_d;
   logic              sr_clr, sr_load, sr_shift;
   logic              addr_ok, new_addr;

   assign addr_ok  = (32'(bus.addr_in) != 32'(NULL_ADDR)) &&
                     (32'(bus.addr_in) <= $unsigned(LAST_ADDR));
   assign new_addr = bus.addr_load && addr_ok;

   // A valid new address always wins and restarts through LOAD; clearing the
   // shifter keeps serial_out low during that dead bit.
   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      bit_cnt_d     = bit_cnt_q;
      byte_loaded_d = 1'b0;
      sr_clr        = 1'b0;
      sr_load       = 1'b0;
      sr_shift      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (new_addr) begin
               rd_addr_d = bus.addr_in;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (new_addr) begin
               rd_addr_d = bus.addr_in;
               sr_clr    = 1'b1;
            end else begin
               sr_load       = 1'b1;
               bit_cnt_d     = '0;
               rd_addr_d     = next_addr(rd_addr_q);
               byte_loaded_d = 1'b1;
               state_d       = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (new_addr) begin
               rd_addr_d = bus.addr_in;
               sr_clr    = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_LOAD;
            end else if (bit_cnt_q == LAST_BIT) begin
               sr_load       = 1'b1;
               bit_cnt_d     = '0;
               rd_addr_d     = next_addr(rd_addr_q);
               byte_loaded_d = 1'b1;
            end else begin
               sr_shift  = 1'b1;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         rd_addr_q     <= '0;
         bit_cnt_q     <= '0;
         byte_loaded_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_loaded_q <= byte_loaded_d;
      end
   end

   poci_shift_register #(.DATA_W(DATA_W)) u_shift (
      .sclk  (sclk),
      .rstn  (rstn),
      .clr   (sr_clr),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (bus.rd_data),
      .dout  (bus.serial_out)
   );

   assign bus.rd_addr     = rd_addr_q;
   assign bus.tx_active   = (state_q != ST_IDLE);
   assign bus.byte_loaded = byte_loaded_q;

endmodule

// File: doc/poci_serializer.md
Name: poci_serializer

Overview:
- Return-direction (peripheral-out) half of the SPI register interface.
- Once the inbound path has captured a non-zero address byte, this block drives that address onto the register read mux. It then serialises the selected 8-bit register MSB-first on serial_out, one bit per sclk.
- After each byte it auto-increments the address and streams the next register until the session reset ends the transaction.
- It runs entirely in the sclk domain; session end (external reset or sclk-stop) arrives through rstn.

Parameters:
- DATA_W, 8, width of a register word and of the shift register.
- ADDR_W, 8, width of the address pointer.
- LAST_ADDR, 255, highest readable address; the pointer wraps from here back to 1.

Ports:
- sclk  input  1  SPI clock; all state updates on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- addr_in  input  ADDR_W  address byte from the inbound deserialiser.
- addr_load  input  1  high for the one sclk cycle in which addr_in holds a complete address byte.
- rd_data  input  DATA_W  combinational read-mux data for rd_addr.
- rd_addr  output  ADDR_W  registered read pointer driving the mux select.
- serial_out  output  1  serial data, equal to the shift register MSB.
- tx_active  output  1  high in LOAD or SHIFT.
- byte_loaded  output  1  one-cycle pulse after each parallel load.

Behaviour:
- Reset (asynchronous, immediate, legal in any state):
  - state=IDLE, rd_addr=0, shift register=0, bit_cnt=0.
  - serial_out=0, tx_active=0, byte_loaded=0.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - serial_out=0.
  - addr_load=1 with 1<=addr_in<=LAST_ADDR: rd_addr<=addr_in, go to LOAD.
  - addr_in=0 or addr_in>LAST_ADDR: ignore, stay IDLE, rd_addr unchanged.
- LOAD (exactly one sclk; the dead bit that gives the mux time to settle):
  - shift<=rd_data, bit_cnt<=0, rd_addr<=next(rd_addr), byte_loaded<=1, go to SHIFT.
  - serial_out stays 0 during the LOAD cycle.
- SHIFT:
  - bit_cnt<7: shift<={shift[DATA_W-2:0],0}, bit_cnt++.
  - bit_cnt==7: shift<=rd_data (mux already points at the next address), rd_addr<=next(rd_addr), bit_cnt<=0, byte_loaded<=1. Bytes stream back-to-back with no gap bit.
- next(a) = (a==LAST_ADDR) ? 1 : a+1. Address 0 is the null pointer and is never emitted.
- byte_loaded is registered: high for exactly the first bit period of each byte, otherwise 0.
- Latency, with posedge P0 = the edge sampling addr_load=1:
  - after P1: serial_out = reg[A][7].
  - after P1+k (k=1..7): serial_out = reg[A][7-k].
  - after P9: serial_out = reg[A+1][7].
- addr_load during LOAD or SHIFT with a valid address:
  - Aborts the current byte; rd_addr<=addr_in, go to LOAD. The new address wins.
  - Invalid address in these states: ignored, streaming continues.
- rd_data is sampled only on load edges. Changes between loads do not affect bits already in flight.
- tx_active is combinational from state: 1 in LOAD and SHIFT, 0 in IDLE.

Decomposition:
- Package poci_pkg:
  - state enum poci_state_t {IDLE, LOAD, SHIFT}.
  - constants DATA_W_DEF=8, ADDR_W_DEF=8, NULL_ADDR='0.
- Sub-module poci_shift_register:
  - Parallel-load, MSB-first left shifter with load/shift enables and async reset.
  - Output = MSB.
- Top level poci_serializer holds the FSM, bit counter and address pointer.

Test Plan:
- Reset then idle: rstn low→high, no addr_load for 20 sclk → serial_out=0, tx_active=0, rd_addr=0 throughout.
- Single read: mux reg[5]=8'hA5, reg[6]=8'h3C; pulse addr_load with addr_in=5 → LOAD at P1 with rd_addr=6 after P1, then serial bits 1,0,1,0,0,1,0,1 after P1..P8, then 0,0,1,1,1,1,0,0; byte_loaded high after P1 and after P9 only.
- Null/invalid address: addr_in=0, and addr_in=300 with ADDR_W=9, LAST_ADDR=255 → state stays IDLE, rd_addr=0, serial_out=0.
- Wrap-around: LAST_ADDR=3, addr_in=3, regs {1:8'h11, 2:8'h22, 3:8'h33} → bytes streamed 33,11,22,33; address 0 never driven.
- Re-address mid-byte: addr_in=2 is streaming and addr_load with addr_in=7 arrives after bit 3 → next cycle is LOAD with serial_out=0, then reg[7] MSB-first; remaining bits of reg[2] are never sent.
- Reset mid-byte: rstn pulsed low between posedges during SHIFT → outputs clear immediately without waiting for an edge; after release, IDLE until the next addr_load.
